// File: rtl/matrix_scan_bcm.sv
// ============================================================================
// matrix_scan_bcm : HUB75 matrix scanner with binary-coded modulation.
// Optional hold-at-frame-end via MATRIX_SCAN_HOLD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_scan_bcm #(
  parameter int COL_BITS     = 6,
  parameter int ROW_BITS     = 4,
  parameter int DEPTH        = 6,
  parameter int BASE_CYCLES  = 1,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk_in,
  input  logic                reset,
`ifdef MATRIX_SCAN_HOLD_EN
  input  logic                hold,
`endif
  output logic [COL_BITS-1:0] column_address,
  output logic [ROW_BITS-1:0] row_address,
  output logic [DEPTH-1:0]    brightness_mask,
  output logic                clk_pixel,
  output logic                row_latch,
  output logic                output_enable,
  output logic                frame_start
);

  localparam int DW = $clog2(BASE_CYCLES << (DEPTH - 1)) + 1;
  localparam int BW = $clog2(BLANK_CYCLES) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = COL_BITS + 1;

`ifdef MATRIX_SCAN_HOLD_EN
  typedef enum logic [2:0] {
    ST_SHIFT   = 3'd0,
    ST_BLANK   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_DISPLAY = 3'd3,
    ST_IDLE    = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_SHIFT   = 2'd0,
    ST_BLANK   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_DISPLAY = 2'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [SW-1:0]       shift_cnt_q, shift_cnt_d;
  logic [BW-1:0]       blank_q, blank_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [PW-1:0]       plane_q, plane_d;
  logic [ROW_BITS-1:0] shift_row_q, shift_row_d;
  logic [ROW_BITS-1:0] row_address_q, row_address_d;
  logic                frame_q, frame_d;
  logic                start_q;

  logic [DW-1:0]       dwell_len;
  logic                shift_last;
  logic                blank_last;
  logic                dwell_last;
  logic                plane_last;
  logic                row_last;

  assign dwell_len  = DW'(BASE_CYCLES) << plane_q;
  assign shift_last = (shift_cnt_q == {SW{1'b1}});
  assign blank_last = (blank_q == BW'(BLANK_CYCLES - 1));
  assign dwell_last = (dwell_q == (dwell_len - DW'(1)));
  assign plane_last = (plane_q == PW'(DEPTH - 1));
  assign row_last   = (shift_row_q == {ROW_BITS{1'b1}});

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q       <= ST_SHIFT;
      shift_cnt_q   <= '0;
      blank_q       <= '0;
      dwell_q       <= '0;
      plane_q       <= '0;
      shift_row_q   <= '0;
      row_address_q <= '0;
      frame_q       <= 1'b0;
      start_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      shift_cnt_q   <= shift_cnt_d;
      blank_q       <= blank_d;
      dwell_q       <= dwell_d;
      plane_q       <= plane_d;
      shift_row_q   <= shift_row_d;
      row_address_q <= row_address_d;
      frame_q       <= frame_d;
      start_q       <= 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_cnt_d   = shift_cnt_q;
    blank_d       = blank_q;
    dwell_d       = dwell_q;
    plane_d       = plane_q;
    shift_row_d   = shift_row_q;
    row_address_d = row_address_q;
    frame_d       = 1'b0;

    // After reset the scanner parks one cycle on column 0 so the
    // first released cycle can carry the frame_start pulse.
    if (start_q) begin
      frame_d = 1'b1;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (shift_last) begin
            shift_cnt_d = '0;
            state_d     = ST_BLANK;
          end else begin
            shift_cnt_d = shift_cnt_q + SW'(1);
          end
        end
        ST_BLANK: begin
          if (blank_last) begin
            blank_d = '0;
            state_d = ST_LATCH;
          end else begin
            blank_d = blank_q + BW'(1);
          end
        end
        ST_LATCH: begin
          row_address_d = shift_row_q;
          state_d       = ST_DISPLAY;
        end
        ST_DISPLAY: begin
          if (dwell_last) begin
            dwell_d = '0;
            state_d = ST_SHIFT;
            if (plane_last) begin
              plane_d     = '0;
              shift_row_d = shift_row_q + ROW_BITS'(1);
              if (row_last) begin
                frame_d = 1'b1;
`ifdef MATRIX_SCAN_HOLD_EN
                if (hold) begin
                  state_d = ST_IDLE;
                  frame_d = 1'b0;
                end
`endif
              end
            end else begin
              plane_d = plane_q + PW'(1);
            end
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
`ifdef MATRIX_SCAN_HOLD_EN
        ST_IDLE: begin
          if (!hold) begin
            state_d = ST_SHIFT;
            frame_d = 1'b1;
          end
        end
`endif
        default: state_d = ST_SHIFT;
      endcase
    end
  end

  // Shift counter LSB is the pixel-clock phase; upper bits are the column.
  assign column_address  = shift_cnt_q[SW-1:1];
  assign clk_pixel       = (state_q == ST_SHIFT) && shift_cnt_q[0];
  assign row_latch       = (state_q == ST_LATCH);
  assign output_enable   = (state_q == ST_DISPLAY);
  assign row_address     = row_address_q;
  assign brightness_mask = DEPTH'(1) << plane_q;
  assign frame_start     = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_bcm.sv
// Bench for matrix_scan_bcm: a small and a default-sized instance checked
// cycle by cycle against expected waveforms built from the plane timing.
`default_nettype none

module tb_matrix_scan_bcm;

  typedef struct packed {
    logic [5:0] col;
    logic [3:0] row;
    logic [5:0] mask;
    logic       cp;
    logic       lat;
    logic       oe;
    logic       fs;
    logic       chk_col;
    logic       chk_row;
    logic       chk_mask;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
`ifdef MATRIX_SCAN_HOLD_EN
  logic hold_s = 1'b0;
  logic hold_d = 1'b0;
`endif

  logic [1:0] s_col;
  logic [0:0] s_row;
  logic [1:0] s_mask;
  logic       s_cp, s_lat, s_oe, s_fs;
  logic [5:0] d_col;
  logic [3:0] d_row;
  logic [5:0] d_mask;
  logic       d_cp, d_lat, d_oe, d_fs;

  exp_t q_s[$];
  exp_t q_d[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk_in = ~clk_in;

  matrix_scan_bcm #(
    .COL_BITS(2), .ROW_BITS(1), .DEPTH(2), .BASE_CYCLES(1), .BLANK_CYCLES(2)
  ) u_small (
    .clk_in(clk_in),
    .reset(reset),
`ifdef MATRIX_SCAN_HOLD_EN
    .hold(hold_s),
`endif
    .column_address(s_col),
    .row_address(s_row),
    .brightness_mask(s_mask),
    .clk_pixel(s_cp),
    .row_latch(s_lat),
    .output_enable(s_oe),
    .frame_start(s_fs)
  );

  matrix_scan_bcm u_dflt (
    .clk_in(clk_in),
    .reset(reset),
`ifdef MATRIX_SCAN_HOLD_EN
    .hold(hold_d),
`endif
    .column_address(d_col),
    .row_address(d_row),
    .brightness_mask(d_mask),
    .clk_pixel(d_cp),
    .row_latch(d_lat),
    .output_enable(d_oe),
    .frame_start(d_fs)
  );

  task automatic compare(input int inst, input exp_t e, input string tag);
    logic [5:0]  col;
    logic [3:0]  row;
    logic [5:0]  mask;
    logic [3:0]  ctl;
    logic [19:0] obs;
    logic [19:0] want;
    if (inst == 0) begin
      col = 6'(s_col); row = 4'(s_row); mask = 6'(s_mask);
      ctl = {s_cp, s_lat, s_oe, s_fs};
    end else begin
      col = d_col; row = d_row; mask = d_mask;
      ctl = {d_cp, d_lat, d_oe, d_fs};
    end
    obs  = {e.chk_col ? col : 6'd0, e.chk_row ? row : 4'd0,
            e.chk_mask ? mask : 6'd0, ctl};
    want = {e.chk_col ? e.col : 6'd0, e.chk_row ? e.row : 4'd0,
            e.chk_mask ? e.mask : 6'd0, e.cp, e.lat, e.oe, e.fs};
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h required %h (col,row,mask,cp,lat,oe,fs)", tag, obs, want);
    end
  endtask

  task automatic push(input int inst, input exp_t e);
    if (inst == 0) q_s.push_back(e);
    else           q_d.push_back(e);
  endtask

  task automatic push_plane(input int inst, input int cols, input int blank,
                            input int base, input int row, input int plane);
    exp_t e;
    for (int c = 0; c < cols; c++) begin
      for (int ph = 0; ph < 2; ph++) begin
        e = '0;
        e.chk_col = 1'b1; e.chk_mask = 1'b1;
        e.mask = 6'(1 << plane);
        e.col  = 6'(c);
        e.cp   = ph[0];
        e.fs   = (row == 0 && plane == 0 && c == 0 && ph == 0);
        push(inst, e);
      end
    end
    for (int i = 0; i < blank; i++) begin
      e = '0; e.chk_col = 1'b1; e.chk_mask = 1'b1; e.mask = 6'(1 << plane);
      push(inst, e);
    end
    e = '0; e.chk_col = 1'b1; e.chk_mask = 1'b1; e.mask = 6'(1 << plane);
    e.lat = 1'b1;
    push(inst, e);
    for (int i = 0; i < (base << plane); i++) begin
      e = '0; e.chk_col = 1'b1; e.chk_mask = 1'b1; e.mask = 6'(1 << plane);
      e.oe = 1'b1; e.chk_row = 1'b1; e.row = 4'(row);
      push(inst, e);
    end
  endtask

  task automatic push_rows(input int inst, input int cols, input int blank,
                           input int base, input int depth, input int nrows);
    for (int r = 0; r < nrows; r++)
      for (int p = 0; p < depth; p++)
        push_plane(inst, cols, blank, base, r, p);
  endtask

  task automatic run_queues(input int budget, input string tag);
    int n = 0;
    while ((q_s.size() > 0 || q_d.size() > 0) && n < budget && fails < 20) begin
      @(negedge clk_in);
      n++;
      if (q_s.size() > 0) compare(0, q_s.pop_front(), $sformatf("%s small cyc %0d", tag, n));
      if (q_d.size() > 0) compare(1, q_d.pop_front(), $sformatf("%s dflt cyc %0d", tag, n));
    end
    tests++;
    assert (q_s.size() == 0 && q_d.size() == 0) else begin
      fails++;
      $error("FAIL %s drain: observed %0d/%0d pending required 0/0", tag, q_s.size(), q_d.size());
    end
    q_s.delete();
    q_d.delete();
  endtask

  initial begin
    exp_t rst_exp;
    logic found;
    rst_exp = '0;
    rst_exp.mask = 6'd1;
    rst_exp.chk_col = 1'b1; rst_exp.chk_row = 1'b1; rst_exp.chk_mask = 1'b1;

    // Reset held for three edges; outputs must sit at reset values.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      compare(0, rst_exp, $sformatf("reset small %0d", i));
      compare(1, rst_exp, $sformatf("reset dflt %0d", i));
    end
    reset = 1'b1;

    // Two small frames (frame_start every 50) and four default rows
    // (masks 1..32, OE runs 1..32).
    push_rows(0, 4, 2, 1, 2, 2);
    push_rows(0, 4, 2, 1, 2, 2);
    push_rows(1, 64, 2, 1, 6, 4);
    run_queues(4000, "scan");

    // Reset during plane 3 of row 5 on the default instance.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk_in);
      if (d_oe && d_mask == 6'd8 && d_row == 4'd5) found = 1'b1;
    end
    tests++;
    assert (found === 1'b1) else begin
      fails++;
      $error("FAIL find row5 plane3: observed %b required 1", found);
    end
    reset = 1'b0;
    @(negedge clk_in);
    compare(0, rst_exp, "mid reset small");
    compare(1, rst_exp, "mid reset dflt");
    reset = 1'b1;
    push_rows(0, 4, 2, 1, 2, 2);
    push_rows(1, 64, 2, 1, 6, 1);
    run_queues(1000, "restart");

`ifdef MATRIX_SCAN_HOLD_EN
    begin
      exp_t idle_e;
      idle_e = '0;
      idle_e.chk_row = 1'b1;
      idle_e.row = 4'd1;
      reset  = 1'b0;
      hold_s = 1'b1;
      @(negedge clk_in);
      compare(0, rst_exp, "hold reset small");
      reset = 1'b1;
      push_rows(0, 4, 2, 1, 2, 2);
      for (int i = 0; i < 20; i++) push(0, idle_e);
      run_queues(200, "hold");
      hold_s = 1'b0;
      push_rows(0, 4, 2, 1, 2, 2);
      run_queues(200, "resume");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
